// File: rtl/pc_sequencer_if.sv
// Fetch/branch-resolution bundle for pc_sequencer: the master side is the
// sequencer itself, the slave side is the surrounding pipeline.
interface pc_sequencer_if #(
   parameter int ADDR_W   = 64,
   parameter int COND_W   = 19,
   parameter int UNCOND_W = 26,
   parameter int CNT_W    = 32
);
   logic                stall;
   logic                fetch_ready;
   logic                fetch_valid;
   logic [ADDR_W-1:0]   pc;
   logic                br_valid;
   logic                br_taken;
   logic                uncond_br;
   logic [COND_W-1:0]   cond_imm;
   logic [UNCOND_W-1:0] br_imm;
   logic [ADDR_W-1:0]   br_pc;
   logic                redirect;
   logic [CNT_W-1:0]    fetch_count;
   logic [CNT_W-1:0]    redirect_count;
   logic [ADDR_W-1:0]   link_addr;
   logic                link_valid;

   modport master (
      input  stall, fetch_ready, br_valid, br_taken, uncond_br,
             cond_imm, br_imm, br_pc,
      output fetch_valid, pc, redirect, fetch_count, redirect_count,
             link_addr, link_valid
   );

   modport slave (
      output stall, fetch_ready, br_valid, br_taken, uncond_br,
             cond_imm, br_imm, br_pc,
      input  fetch_valid, pc, redirect, fetch_count, redirect_count,
             link_addr, link_valid
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: sequential advance, PC-relative redirects,
// saturating perf counters. Optional link register: PC_SEQUENCER_BR_LINK_EN.
module pc_sequencer #(
   parameter int                ADDR_W   = 64,
   parameter int                COND_W   = 19,
   parameter int                UNCOND_W = 26,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 32
) (
   input  logic          clk,
   input  logic          reset,
   pc_sequencer_if.master bus
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic                     r_fetch_valid, r_fetch_valid_nxt;
   logic [ADDR_W-1:0]        r_pc, r_pc_nxt;
   logic                     r_redirect, r_redirect_nxt;
   logic [CNT_W-1:0]         r_fetch_cnt, r_fetch_cnt_nxt;
   logic [CNT_W-1:0]         r_redir_cnt, r_redir_cnt_nxt;

   logic signed [ADDR_W-1:0] w_off;
   logic [ADDR_W-1:0]        w_target;
   logic                     w_hs;
   logic                     w_redir;

   // Immediates count instruction words; sign-extend before scaling to bytes.
   assign w_off    = bus.uncond_br
                   ? {{(ADDR_W-UNCOND_W){bus.br_imm[UNCOND_W-1]}}, bus.br_imm}
                   : {{(ADDR_W-COND_W){bus.cond_imm[COND_W-1]}}, bus.cond_imm};
   assign w_target = bus.br_pc + ADDR_W'(w_off <<< 2);
   assign w_hs     = r_fetch_valid & bus.fetch_ready & ~bus.stall;
   assign w_redir  = bus.br_valid & bus.br_taken;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_valid <= 1'b0;
         r_pc          <= RESET_PC;
         r_redirect    <= 1'b0;
         r_fetch_cnt   <= '0;
         r_redir_cnt   <= '0;
      end else begin
         r_fetch_valid <= r_fetch_valid_nxt;
         r_pc          <= r_pc_nxt;
         r_redirect    <= r_redirect_nxt;
         r_fetch_cnt   <= r_fetch_cnt_nxt;
         r_redir_cnt   <= r_redir_cnt_nxt;
      end
   end

   // A redirect wins over the sequential address but the fetch still counts.
   always_comb begin
      r_fetch_valid_nxt = 1'b1;
      r_pc_nxt          = r_pc;
      r_redirect_nxt    = w_redir;
      r_fetch_cnt_nxt   = r_fetch_cnt;
      r_redir_cnt_nxt   = r_redir_cnt;
      if (w_hs) begin
         r_fetch_cnt_nxt = sat_inc(r_fetch_cnt);
         r_pc_nxt        = r_pc + ADDR_W'(4);
      end
      if (w_redir) begin
         r_redir_cnt_nxt = sat_inc(r_redir_cnt);
         r_pc_nxt        = w_target;
      end
   end

   always_comb begin
      bus.fetch_valid    = r_fetch_valid;
      bus.pc             = r_pc;
      bus.redirect       = r_redirect;
      bus.fetch_count    = r_fetch_cnt;
      bus.redirect_count = r_redir_cnt;
   end

`ifdef PC_SEQUENCER_BR_LINK_EN
   logic [ADDR_W-1:0] r_link_addr;
   logic              r_link_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_link_addr  <= '0;
         r_link_valid <= 1'b0;
      end else begin
         r_link_valid <= w_redir & bus.uncond_br;
         if (w_redir & bus.uncond_br)
            r_link_addr <= bus.br_pc + ADDR_W'(4);
      end
   end

   assign bus.link_addr  = r_link_addr;
   assign bus.link_valid = r_link_valid;
`else
   assign bus.link_addr  = '0;
   assign bus.link_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (CNT_W=4 so counter saturation is reachable).
module tb_pc_sequencer;

   localparam int ADDR_W = 64;
   localparam int CNT_W  = 4;

   typedef struct {
      logic [63:0] pc;
      logic        fv;
      logic        red;
      logic [3:0]  fc;
      logic [3:0]  rc;
      logic [63:0] la;
      logic        lv;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   vecs = 0;
   int   errs = 0;

   exp_t sb[$];
   exp_t e;

   logic [63:0] m_pc = '0;
   logic        m_fv = 1'b0;
   logic [3:0]  m_fc = '0;
   logic [3:0]  m_rc = '0;
   logic [63:0] m_la = '0;

   pc_sequencer_if #(.ADDR_W(ADDR_W), .COND_W(19), .UNCOND_W(26), .CNT_W(CNT_W)) bus ();

   pc_sequencer #(.ADDR_W(ADDR_W), .COND_W(19), .UNCOND_W(26),
                  .RESET_PC(64'h0), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Drives one cycle of inputs, pushes the model's expectation, waits past the edge.
   task automatic drive(input logic rst, input logic st, input logic rdy,
                        input logic bv, input logic bt, input logic ub,
                        input logic [18:0] ci, input logic [25:0] bi,
                        input logic [63:0] bpc);
      exp_t   x;
      longint off;
      logic   hs, rd;
      reset           = rst;
      bus.stall       = st;
      bus.fetch_ready = rdy;
      bus.br_valid    = bv;
      bus.br_taken    = bt;
      bus.uncond_br   = ub;
      bus.cond_imm    = ci;
      bus.br_imm      = bi;
      bus.br_pc       = bpc;
      x.lv = 1'b0;
      if (rst) begin
         m_pc = 64'h0; m_fv = 1'b0; m_fc = '0; m_rc = '0; m_la = '0;
         x.red = 1'b0;
      end else begin
         hs  = m_fv & rdy & ~st;
         rd  = bv & bt;
         off = ub ? longint'($signed(bi)) : longint'($signed(ci));
         if (hs && m_fc != 4'hF) m_fc = m_fc + 4'd1;
         if (rd && m_rc != 4'hF) m_rc = m_rc + 4'd1;
         if (rd)      m_pc = bpc + 64'(off * 4);
         else if (hs) m_pc = m_pc + 64'd4;
         m_fv  = 1'b1;
         x.red = rd;
`ifdef PC_SEQUENCER_BR_LINK_EN
         if (rd && ub) begin
            m_la = bpc + 64'd4;
            x.lv = 1'b1;
         end
`endif
      end
      x.pc = m_pc; x.fv = m_fv; x.fc = m_fc; x.rc = m_rc; x.la = m_la;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 19'h0, 26'h0, 64'h0);
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0, 26'h0, 64'h0);
      e = sb.pop_front();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'h5, 26'h5, 64'h80);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc) begin errs++; $display("FAIL rst_pc: got %h want %h", bus.pc, e.pc); end
      vecs++; if (bus.fetch_valid !== e.fv) begin errs++; $display("FAIL rst_fv: got %b want %b", bus.fetch_valid, e.fv); end
      vecs++; if (bus.redirect !== e.red) begin errs++; $display("FAIL rst_redir: got %b want %b", bus.redirect, e.red); end
      vecs++; if (bus.fetch_count !== e.fc || bus.redirect_count !== e.rc) begin errs++; $display("FAIL rst_cnt: got %0d/%0d want %0d/%0d", bus.fetch_count, bus.redirect_count, e.fc, e.rc); end
      vecs++; if (bus.link_addr !== e.la || bus.link_valid !== e.lv) begin errs++; $display("FAIL rst_link: got %h/%b want %h/%b", bus.link_addr, bus.link_valid, e.la, e.lv); end
   endtask

   task automatic test_sequential;
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         e = sb.pop_front();
         vecs++; if (bus.pc !== e.pc) begin errs++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, e.pc); end
         vecs++; if (bus.fetch_valid !== e.fv) begin errs++; $display("FAIL seq_fv[%0d]: got %b want %b", i, bus.fetch_valid, e.fv); end
         vecs++; if (bus.fetch_count !== e.fc) begin errs++; $display("FAIL seq_fc[%0d]: got %0d want %0d", i, bus.fetch_count, e.fc); end
      end
      vecs++; if (bus.pc !== 64'hC || bus.fetch_count !== 4'd3) begin errs++; $display("FAIL seq_end: got pc %h cnt %0d want c/3", bus.pc, bus.fetch_count); end
   endtask

   task automatic test_stall;
      idle(1'b1);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc) begin errs++; $display("FAIL stall_pre_pc: got %h want %h", bus.pc, e.pc); end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0, 26'h0, 64'h0);
         e = sb.pop_front();
         vecs++; if (bus.pc !== e.pc || bus.pc !== 64'h10) begin errs++; $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.pc, e.pc); end
         vecs++; if (bus.fetch_count !== e.fc) begin errs++; $display("FAIL stall_fc[%0d]: got %0d want %0d", i, bus.fetch_count, e.fc); end
      end
      // Not ready: pc and valid are stable.
      idle(1'b0);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc || bus.fetch_valid !== e.fv) begin errs++; $display("FAIL noready: got %h/%b want %h/%b", bus.pc, bus.fetch_valid, e.pc, e.fv); end
   endtask

   task automatic test_cond_branch;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h7FFFF, 26'h0, 64'h100);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc) begin errs++; $display("FAIL cond_pc: got %h want %h", bus.pc, e.pc); end
      vecs++; if (bus.redirect !== e.red) begin errs++; $display("FAIL cond_redir: got %b want %b", bus.redirect, e.red); end
      vecs++; if (bus.redirect_count !== e.rc) begin errs++; $display("FAIL cond_rc: got %0d want %0d", bus.redirect_count, e.rc); end
      vecs++; if (bus.link_valid !== e.lv) begin errs++; $display("FAIL cond_lv: got %b want %b", bus.link_valid, e.lv); end
      idle(1'b0);
      e = sb.pop_front();
      vecs++; if (bus.redirect !== e.red || bus.pc !== e.pc) begin errs++; $display("FAIL cond_after: got %b/%h want %b/%h", bus.redirect, bus.pc, e.red, e.pc); end
   endtask

   task automatic test_uncond_branch;
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 19'h0, 26'd16, 64'h200);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc) begin errs++; $display("FAIL unc_pc: got %h want %h", bus.pc, e.pc); end
      vecs++; if (bus.redirect !== e.red) begin errs++; $display("FAIL unc_redir: got %b want %b", bus.redirect, e.red); end
      vecs++; if (bus.link_addr !== e.la || bus.link_valid !== e.lv) begin errs++; $display("FAIL unc_link: got %h/%b want %h/%b", bus.link_addr, bus.link_valid, e.la, e.lv); end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 19'h0, 26'd16, 64'h200);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc || bus.redirect !== e.red) begin errs++; $display("FAIL unc_nt: got %h/%b want %h/%b", bus.pc, bus.redirect, e.pc, e.red); end
      vecs++; if (bus.redirect_count !== e.rc || bus.link_valid !== e.lv || bus.link_addr !== e.la) begin errs++; $display("FAIL unc_nt_side: got %0d/%b/%h want %0d/%b/%h", bus.redirect_count, bus.link_valid, bus.link_addr, e.rc, e.lv, e.la); end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 19'h0, 26'd40, 64'h300);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc || bus.redirect !== e.red || bus.redirect_count !== e.rc) begin errs++; $display("FAIL unc_novalid: got %h/%b/%0d want %h/%b/%0d", bus.pc, bus.redirect, bus.redirect_count, e.pc, e.red, e.rc); end
   endtask

   task automatic test_back_to_back;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 19'h00010, 26'h0, 64'h1000);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc) begin errs++; $display("FAIL b2b_pc: got %h want %h", bus.pc, e.pc); end
      vecs++; if (bus.fetch_count !== e.fc || bus.redirect_count !== e.rc) begin errs++; $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", bus.fetch_count, bus.redirect_count, e.fc, e.rc); end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'h0, 26'h3FFFFF8, 64'h2000);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc || bus.redirect !== e.red) begin errs++; $display("FAIL b2b_neg: got %h/%b want %h/%b", bus.pc, bus.redirect, e.pc, e.red); end
      vecs++; if (bus.link_addr !== e.la || bus.link_valid !== e.lv) begin errs++; $display("FAIL b2b_link: got %h/%b want %h/%b", bus.link_addr, bus.link_valid, e.la, e.lv); end
   endtask

   task automatic test_wrap;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h0, 26'h0, 64'hFFFF_FFFF_FFFF_FFFC);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc) begin errs++; $display("FAIL wrap_set: got %h want %h", bus.pc, e.pc); end
      idle(1'b1);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc || bus.pc !== 64'h0) begin errs++; $display("FAIL wrap_pc: got %h want %h", bus.pc, e.pc); end
   endtask

   task automatic test_saturation;
      test_reset();
      for (int i = 0; i < 20; i++) begin
         idle(1'b1);
         e = sb.pop_front();
         vecs++; if (bus.fetch_count !== e.fc) begin errs++; $display("FAIL sat_fc[%0d]: got %0d want %0d", i, bus.fetch_count, e.fc); end
      end
      vecs++; if (bus.fetch_count !== 4'd15) begin errs++; $display("FAIL sat_fc_end: got %0d want 15", bus.fetch_count); end
      for (int i = 0; i < 18; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'(i), 26'h0, 64'h4000);
         e = sb.pop_front();
         vecs++; if (bus.redirect_count !== e.rc || bus.pc !== e.pc) begin errs++; $display("FAIL sat_rc[%0d]: got %0d/%h want %0d/%h", i, bus.redirect_count, bus.pc, e.rc, e.pc); end
      end
   endtask

   task automatic test_reset_midrun;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'h0, 26'd16, 64'h200);
      e = sb.pop_front();
      vecs++; if (bus.pc !== 64'h240) begin errs++; $display("FAIL mid_pre: got %h want 240", bus.pc); end
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'h0, 26'd16, 64'h200);
      e = sb.pop_front();
      vecs++; if (bus.pc !== e.pc || bus.fetch_valid !== e.fv || bus.redirect !== e.red) begin errs++; $display("FAIL mid_rst: got %h/%b/%b want %h/%b/%b", bus.pc, bus.fetch_valid, bus.redirect, e.pc, e.fv, e.red); end
      vecs++; if (bus.fetch_count !== e.fc || bus.redirect_count !== e.rc || bus.link_valid !== e.lv || bus.link_addr !== e.la) begin errs++; $display("FAIL mid_cnt: got %0d/%0d/%b/%h want %0d/%0d/%b/%h", bus.fetch_count, bus.redirect_count, bus.link_valid, bus.link_addr, e.fc, e.rc, e.lv, e.la); end
      idle(1'b1);
      e = sb.pop_front();
      vecs++; if (bus.fetch_valid !== e.fv || bus.pc !== e.pc) begin errs++; $display("FAIL mid_after: got %b/%h want %b/%h", bus.fetch_valid, bus.pc, e.fv, e.pc); end
   endtask

   initial begin
      reset = 1'b1;
      bus.stall = 1'b0; bus.fetch_ready = 1'b0; bus.br_valid = 1'b0; bus.br_taken = 1'b0;
      bus.uncond_br = 1'b0; bus.cond_imm = '0; bus.br_imm = '0; bus.br_pc = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_sequential();
      test_stall();
      test_cond_branch();
      test_uncond_branch();
      test_back_to_back();
      test_wrap();
      test_saturation();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
